// File: rtl/demux18_deser_pkg.sv
// Shared definitions for the serial-to-parallel demultiplexer.
//   DEFAULT_W  : default word width (power of two, >= 2)
//   sel_width(): width of a position counter that addresses every bit of a word
//   W_LAST     : index of the last bit of a default-width word
package demux_pkg;

    localparam int DEFAULT_W = 8;

    function automatic int sel_width(input int w);
        return $clog2(w);
    endfunction

    localparam int W_LAST = DEFAULT_W - 1;

endpackage

// File: rtl/demux18_deser_dec.sv
// 1:W one-hot write-enable decoder; the write-side inverse of an out = in[sel]
// bit-select mux.
//   sel : position to enable
//   en  : global enable; when low every output is low
//   we  : one-hot write enables, bit sel set when en is high
module demux18_dec
    import demux_pkg::*;
#(
    parameter int W = DEFAULT_W,
    localparam int SEL_W = sel_width(W)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [W-1:0]     we
);

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_we
            assign we[gi] = en && (sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/demux18_deser.sv
// Serial-to-parallel demultiplexer. Each accepted bit lands at word position
// sel (LSB first); a completed word moves to a one-deep output register with a
// valid/ready handshake.
//   clk, rst   : clock and synchronous active-high reset
//   flush      : discard the partial word (output register untouched)
//   in_bit     : serial data, qualified by in_valid, accepted when in_ready
//   out_word   : assembled word, qualified by out_valid, taken when out_ready
//   sel        : position the next accepted bit will occupy
module demux18_deser
    import demux_pkg::*;
#(
    parameter int W = DEFAULT_W,
    localparam int SEL_W = sel_width(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(W - 1);

    logic [SEL_W-1:0] sel_reg,       sel_next;
    logic [W-1:0]     acc_reg,       acc_next;
    logic [W-1:0]     out_word_reg,  out_word_next;
    logic             out_valid_reg, out_valid_next;

    logic         accept;
    logic         complete;
    logic         at_last;
    logic [W-1:0] we;

    assign at_last = (sel_reg == SEL_LAST);

    // The last bit is held off only while the previous word is still waiting.
    // out_ready deliberately does not feed in_ready, so a drain releases the
    // last bit one cycle later.
    assign in_ready = !rst && !flush && !(at_last && out_valid_reg);
    assign accept   = in_valid && in_ready;
    assign complete = accept && at_last;

    demux18_dec #(.W(W)) u_dec (
        .sel (sel_reg),
        .en  (accept),
        .we  (we)
    );

    // Accumulator bits clear on flush and on completion, so the next word
    // never carries stale bits.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_acc
            assign acc_next[gi] = (flush || complete) ? 1'b0
                                : (we[gi] ? in_bit : acc_reg[gi]);
        end
    endgenerate

    always_comb begin
        sel_next = sel_reg;
        if (flush) begin
            sel_next = '0;
        end else if (accept) begin
            sel_next = at_last ? '0 : sel_reg + 1'b1;
        end
    end

    // A completion overrides a coincident drain: the new word loads and
    // out_valid stays high.
    always_comb begin
        out_word_next  = out_word_reg;
        out_valid_next = out_valid_reg;
        if (complete) begin
            out_word_next  = {in_bit, acc_reg[W-2:0]};
            out_valid_next = 1'b1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg       <= '0;
            acc_reg       <= '0;
            out_word_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            sel_reg       <= sel_next;
            acc_reg       <= acc_next;
            out_word_reg  <= out_word_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign sel       = sel_reg;
    assign out_word  = out_word_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_demux18_deser.sv
module tb_demux18_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_bit = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_word;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [2:0]   sel;

    int n_checks = 0;
    int n_fail   = 0;
    bit monitor_on = 1'b0;
    bit rnd_on = 1'b0;

    // Reference model: the bits of the word in progress, and the words that
    // have been completed but not yet taken by the consumer.
    logic         bit_q[$];
    logic [W-1:0] word_q[$];
    logic [W-1:0] last_word = '0;

    demux18_deser #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack_bits();
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) w[i] = bit_q[i];
        return w;
    endfunction

    // Monitor/scoreboard: check DUT state against the model mid-cycle, then
    // advance the model to what the coming rising edge should produce.
    always @(negedge clk) begin
        if (monitor_on) begin
            logic exp_valid;
            logic exp_ready;
            exp_valid = (word_q.size() != 0);
            exp_ready = !rst && !flush && !((bit_q.size() == W - 1) && exp_valid);
            check("sel", 32'(sel), 32'(bit_q.size()));
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("out_word", 32'(out_word), 32'(exp_valid ? word_q[0] : last_word));
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            if (rst) begin
                bit_q.delete();
                word_q.delete();
                last_word = '0;
            end else begin
                if (out_valid && out_ready && word_q.size() != 0) begin
                    last_word = word_q.pop_front();
                    $display("word taken: %02h", last_word);
                end
                if (flush) begin
                    bit_q.delete();
                end else if (in_valid && in_ready) begin
                    bit_q.push_back(in_bit);
                    if (bit_q.size() == W) begin
                        word_q.push_back(pack_bits());
                        bit_q.delete();
                    end
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        int guard;
        logic acc_seen;
        guard = 0;
        in_valid = 1'b1;
        in_bit   = b;
        do begin
            @(negedge clk);
            acc_seen = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc_seen && guard < 200);
        if (!acc_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready expected accept within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic drive_word(input logic [W-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) drive_bit(w[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [W-1:0] pat;

        // Reset held for a few edges
        @(posedge clk);
        #1;
        monitor_on = 1'b1;
        idle(2);
        rst = 1'b0;

        // 1: back-to-back word with consumer ready, then mux round-trip
        out_ready = 1'b1;
        pat = 8'h4D;
        drive_word(pat, W);
        @(negedge clk);
        check("t1_word", 32'(out_word), 32'h4D);
        for (int s = 0; s < W; s++) check("t1_mux", 32'(out_word[s]), 32'(pat[s]));
        @(posedge clk);
        #1;
        idle(2);

        // 2: backpressure, second word stalls on its last bit until drain
        out_ready = 1'b0;
        drive_word(8'hA5, W);
        fork
            drive_word(8'h3C, W);
            begin
                idle(14);
                out_ready = 1'b1;
                idle(1);
                out_ready = 1'b0;
            end
        join
        idle(2);
        @(negedge clk);
        check("t2_word", 32'(out_word), 32'h3C);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(2);

        // 3: partial word, flush with a coincident valid bit, then clean word
        drive_word(8'h07, 3);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        flush    = 1'b1;
        idle(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        drive_word(8'h90, W);
        @(negedge clk);
        check("t3_word", 32'(out_word), 32'h90);
        @(posedge clk);
        #1;
        idle(1);

        // 4: word held, consumer drains while the next word's last bit waits
        out_ready = 1'b0;
        drive_word(8'h5A, W);
        drive_word(8'hC3, W - 1);
        out_ready = 1'b1;
        drive_bit(1'b1);
        idle(2);

        // 5: reset mid-word with a held word
        out_ready = 1'b0;
        drive_word(8'hF0, W);
        drive_word(8'h1F, 5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);

        // 6: random stream with random gaps and random consumer stalls
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    for (int g = 0; g < gap; g++) begin
                        in_bit = 1'($urandom);
                        idle(1);
                    end
                    drive_bit(1'($urandom));
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    idle(1);
                end
            end
        join
        out_ready = 1'b1;
        idle(4);
        @(negedge clk);
        check("leftover_words", 32'(word_q.size()), 32'd0);
        check("leftover_bits", 32'(bit_q.size()), 32'(sel));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
